// File: rtl/i2c_bus_mon.sv
// Passive I2C bus monitor: synchronise/filter SCL+SDA, decode START/STOP, capture bytes into a FIFO.
// Optional SCL-low timeout enabled by defining I2C_BUS_MON_TIMEOUT_EN.
module i2c_bus_mon #(
    parameter int FILTER_LEN     = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       bus_busy,
    output logic [1:0] bus_state,
    output logic       evt_start,
    output logic       evt_rstart,
    output logic       evt_stop,
    output logic       evt_partial,
    output logic       evt_timeout,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_ack,
    output logic       byte_first,
    output logic       overflow
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_ACK = 2'd2} state_t;

    logic [1:0]    sync1_r, sync2_r, filt_r, prev_r;
    logic [FW-1:0] fcnt_r [2];
    state_t        state_r, state_n;
    logic [3:0]    bit_cnt_r, bit_cnt_n;
    logic          first_r, first_n;
    logic [7:0]    shreg_r, shreg_n;
    logic          evt_start_n, evt_rstart_n, evt_stop_n, evt_partial_n, evt_timeout_n;
    logic          push_s, timeout_s, mid_byte_s;
    logic          scl_f_s, sda_f_s, start_det_s, stop_det_s, scl_rise_s;
    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic          empty_s, full_s, pop_s, wr_en_s, ovf_s;
    logic [9:0]    head_s;

    // Two-flop synchroniser followed by a consecutive-sample filter; index 0 = SCL, 1 = SDA
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
            filt_r  <= 2'b11;
            prev_r  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_r[i] <= '0;
        end else begin
            sync1_r <= {sda_in, scl_in};
            sync2_r <= sync1_r;
            prev_r  <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == FW'(FILTER_LEN - 1)) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FW'(1);
                end
            end
        end
    end

    assign scl_f_s     = filt_r[0];
    assign sda_f_s     = filt_r[1];
    // SDA edges only count as START/STOP when SCL was high on both sides of the edge
    assign start_det_s = prev_r[0] && scl_f_s && prev_r[1] && !sda_f_s;
    assign stop_det_s  = prev_r[0] && scl_f_s && !prev_r[1] && sda_f_s;
    assign scl_rise_s  = !prev_r[0] && scl_f_s;
    assign mid_byte_s  = (state_r == ST_ACK) || ((state_r == ST_DATA) && (bit_cnt_r != 4'd0));

`ifdef I2C_BUS_MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_r;

    assign timeout_s = (state_r != ST_IDLE) && !scl_f_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Counts consecutive busy cycles with filtered SCL low
    always_ff @(posedge clk) begin
        if (reset || (state_r == ST_IDLE) || scl_f_s || timeout_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Bus protocol FSM: next state, byte assembly and event decode
    always_comb begin
        state_n       = state_r;
        bit_cnt_n     = bit_cnt_r;
        first_n       = first_r;
        shreg_n       = shreg_r;
        push_s        = 1'b0;
        evt_start_n   = 1'b0;
        evt_rstart_n  = 1'b0;
        evt_stop_n    = 1'b0;
        evt_partial_n = 1'b0;
        evt_timeout_n = 1'b0;
        if (stop_det_s) begin
            evt_stop_n    = 1'b1;
            evt_partial_n = mid_byte_s;
            state_n       = ST_IDLE;
            bit_cnt_n     = 4'd0;
            first_n       = 1'b0;
        end else if (start_det_s) begin
            if (state_r == ST_IDLE) begin
                evt_start_n = 1'b1;
            end else begin
                evt_rstart_n  = 1'b1;
                evt_partial_n = mid_byte_s;
            end
            state_n   = ST_DATA;
            bit_cnt_n = 4'd0;
            first_n   = 1'b1;
        end else if (timeout_s) begin
            evt_timeout_n = 1'b1;
            evt_partial_n = mid_byte_s;
            state_n       = ST_IDLE;
            bit_cnt_n     = 4'd0;
            first_n       = 1'b0;
        end else if (scl_rise_s) begin
            case (state_r)
                ST_DATA: begin
                    shreg_n   = {shreg_r[6:0], sda_f_s};
                    bit_cnt_n = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd7) begin
                        state_n = ST_ACK;
                    end else begin
                        state_n = ST_DATA;
                    end
                end
                ST_ACK: begin
                    push_s    = 1'b1;
                    first_n   = 1'b0;
                    bit_cnt_n = 4'd0;
                    state_n   = ST_DATA;
                end
                default: state_n = ST_IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // FSM state and registered event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            first_r     <= 1'b0;
            shreg_r     <= 8'd0;
            evt_start   <= 1'b0;
            evt_rstart  <= 1'b0;
            evt_stop    <= 1'b0;
            evt_partial <= 1'b0;
            evt_timeout <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            first_r     <= first_n;
            shreg_r     <= shreg_n;
            evt_start   <= evt_start_n;
            evt_rstart  <= evt_rstart_n;
            evt_stop    <= evt_stop_n;
            evt_partial <= evt_partial_n;
            evt_timeout <= evt_timeout_n;
        end
    end

    assign bus_state = state_r;
    assign bus_busy  = (state_r != ST_IDLE);

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = !empty_s && byte_ready;
    // A pop in the same cycle frees the slot, so a full-FIFO push still lands
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign ovf_s   = push_s && full_s && !pop_s;

    // FIFO storage; entry layout is {first, ack, data}
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {first_r, ~sda_f_s, shreg_r};
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            if (ovf_s)   overflow <= 1'b1;
        end
    end

    // Head entry is forced to zero while empty so outputs read 0 after reset
    always_comb begin
        head_s = 10'd0;
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            head_s = 10'd0;
        end
    end

    assign byte_valid = !empty_s;
    assign byte_first = head_s[9];
    assign byte_ack   = head_s[8];
    assign byte_data  = head_s[7:0];
endmodule
